// File: rtl/inst_mem_resp_if.sv
// rtl/inst_mem_resp_if.sv - fetch request/response and program-load bus for inst_mem_resp
interface inst_mem_resp_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_inst_o;
    logic        rsp_err_o;
    logic        ld_we_i;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_data_i;

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
        input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
        output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
    );
endinterface

// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - instruction memory responder, fixed-latency in-order fetch with credit flow control
// Optional misaligned-access checking on both ports: define INST_MEM_ALIGN_CHECK_EN.
module inst_mem_resp #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    inst_mem_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CW = $clog2(LATENCY + 1);

`ifdef INST_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] req_word;
    logic [31:0] ld_word;
    logic        req_bad;
    logic        ld_ok;

    assign req_word = {2'b00, bus.req_addr_i[31:2]};
    assign ld_word  = {2'b00, bus.ld_addr_i[31:2]};
    assign req_bad  = (req_word >= 32'(DEPTH_WORDS)) ||
                      (ALIGN_CHECK && (bus.req_addr_i[1:0] != 2'b00));
    assign ld_ok    = bus.ld_we_i && (ld_word < 32'(DEPTH_WORDS)) &&
                      !(ALIGN_CHECK && (bus.ld_addr_i[1:0] != 2'b00));

    // Program storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_word[AW-1:0]] <= bus.ld_data_i;
        end
    end

    logic          pipe_vld  [LATENCY];
    logic [31:0]   pipe_data [LATENCY];
    logic          pipe_err  [LATENCY];
    logic [31:0]   fifo_data [LATENCY];
    logic          fifo_err  [LATENCY];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] credit_cnt;

    logic rsp_valid;
    logic pop;
    logic push;
    logic accept;
    logic req_ready;

    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && bus.rsp_ready_i;
    assign push      = pipe_vld[LATENCY-1];
    // A pop in the same cycle frees a credit, keeping one-per-cycle throughput at full occupancy.
    assign req_ready = !rst && !bus.ld_we_i && ((credit_cnt < CW'(LATENCY)) || pop);
    assign accept    = bus.req_valid_i && req_ready;

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_inst_o  = rsp_valid ? fifo_data[rd_ptr] : NOP_INST;
    assign bus.rsp_err_o   = rsp_valid && fifo_err[rd_ptr];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(LATENCY - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= NOP_INST;
                pipe_err[i]  <= 1'b0;
                fifo_data[i] <= NOP_INST;
                fifo_err[i]  <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            credit_cnt <= '0;
        end else begin
            pipe_vld[0]  <= accept;
            pipe_data[0] <= req_bad ? NOP_INST : mem[req_word[AW-1:0]];
            pipe_err[0]  <= req_bad;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_err[i]  <= pipe_err[i-1];
            end

            // Credits bound pipeline+FIFO occupancy, so a push never finds the FIFO full.
            if (push) begin
                fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
                fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
                wr_ptr            <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            case ({accept, pop})
                2'b10:   credit_cnt <= credit_cnt + CW'(1);
                2'b01:   credit_cnt <= credit_cnt - CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb/tb_inst_mem_resp.sv - self-checking bench for inst_mem_resp against a queue-based reference model
module tb_inst_mem_resp;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef INST_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_resp_if bus();

    inst_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [int];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_fetch(input logic [31:0] addr, output logic [31:0] inst,
                                        output logic err);
        int idx = int'(addr >> 2);
        if ((addr >> 2) >= DEPTH || (ALIGN && addr[1:0] != 2'b00)) begin
            inst = NOP;
            err  = 1'b1;
        end else begin
            inst = mm.exists(idx) ? mm[idx] : 32'hxxxx_xxxx;
            err  = 1'b0;
        end
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        logic exp_valid, pop_m, exp_ready;
        logic [31:0] inst;
        logic err;
        rsp_t r;
        @(negedge clk);
        exp_valid = !rst && q.size() > 0 && q[0].due <= cyc;
        pop_m     = exp_valid && bus.rsp_ready_i;
        exp_ready = !rst && !bus.ld_we_i && (q.size() < LAT || pop_m);
        chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_inst", bus.rsp_inst_o, q[0].inst);
            chk("rsp_err", 32'(bus.rsp_err_o), 32'(q[0].err));
        end
        if (pop_m) void'(q.pop_front());
        if (exp_ready && bus.req_valid_i) begin
            model_fetch(bus.req_addr_i, inst, err);
            r.inst = inst;
            r.err  = err;
            r.due  = cyc + 1 + LAT;
            q.push_back(r);
        end
        if (!rst && bus.ld_we_i && (bus.ld_addr_i >> 2) < DEPTH &&
            !(ALIGN && bus.ld_addr_i[1:0] != 2'b00))
            mm[int'(bus.ld_addr_i >> 2)] = bus.ld_data_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic rr,
                         input logic we, input logic [31:0] la, input logic [31:0] ld);
        bus.req_valid_i = v;
        bus.req_addr_i  = a;
        bus.rsp_ready_i = rr;
        bus.ld_we_i     = we;
        bus.ld_addr_i   = la;
        bus.ld_data_i   = ld;
        step();
    endtask

    task automatic drain();
        int budget = 20;
        while (q.size() > 0 && budget > 0) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
            budget--;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_inst", bus.rsp_inst_o, NOP);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Preload words 2..63 with fetches pending to exercise load blocking.
        for (int i = 2; i < 64; i++)
            drive(1'b1, 32'(i * 4), 1'b1, 1'b1, 32'(i * 4), $urandom);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0050_0093);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h0010_8113);

        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
        drain();

        // Back-pressure: only LAT of four attempts fit, head must stay stable.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();

        drive(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'h0);
        drain();

        drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'hCAFE_0001);
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h0);
        drain();

        drive(1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 32'hDEAD_BEEF);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_8000, 32'h1234_5678);
        drain();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h4000 + ($urandom_range(0, 255) << 2)
                                            : ($urandom_range(0, 63) << 2);
            a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            drive(1'($urandom), a, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) << 2), $urandom);
        end
        drain();

        // Asynchronous reset with responses buffered and in flight.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_rsp_inst", bus.rsp_inst_o, NOP);
        chk("mid_rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        q.delete();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
